// File: rtl/alu16_lp.sv
// 16-bit, 16-operation ALU with registered result/carry, an update enable and
// per-group operand isolation so idle or unselected datapath sections see zeros.
module alu16_lp (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  s,
  output logic [15:0] yout,
  output logic        carry
);

  logic [15:0] y_q, y_d;
  logic        c_q, c_d;

  // Group decode: arith 0-3, logic 4-10, shift 11-14, compare 15.
  logic sel_ar, sel_lg, sel_sh, sel_cmp;
  assign sel_ar  = en && (s[3:2] == 2'b00);
  assign sel_lg  = en && (s >= 4'd4) && (s <= 4'd10);
  assign sel_sh  = en && (s >= 4'd11) && (s <= 4'd14);
  assign sel_cmp = en && (s == 4'd15);

  logic [15:0] a_ar, b_ar, a_lg, b_lg, a_sh, a_cmp, b_cmp;
  assign a_ar  = sel_ar  ? a : 16'h0000;
  assign b_ar  = sel_ar  ? b : 16'h0000;
  assign a_lg  = sel_lg  ? a : 16'h0000;
  assign b_lg  = sel_lg  ? b : 16'h0000;
  assign a_sh  = sel_sh  ? a : 16'h0000;
  assign a_cmp = sel_cmp ? a : 16'h0000;
  assign b_cmp = sel_cmp ? b : 16'h0000;

  // Arithmetic: bit 16 of the 17-bit result is carry (add) or borrow (sub).
  logic [16:0] ar_r;
  always_comb begin
    ar_r = 17'd0;
    case (s[1:0])
      2'd0: ar_r = {1'b0, a_ar} + {1'b0, b_ar};
      2'd1: ar_r = {1'b0, a_ar} - {1'b0, b_ar};
      2'd2: ar_r = {1'b0, a_ar} + 17'd1;
      default: ar_r = {1'b0, a_ar} - 17'd1;
    endcase
  end

  logic [15:0] lg_r;
  always_comb begin
    lg_r = 16'h0000;
    case (s)
      4'd4:    lg_r = a_lg & b_lg;
      4'd5:    lg_r = a_lg | b_lg;
      4'd6:    lg_r = a_lg ^ b_lg;
      4'd7:    lg_r = ~a_lg;
      4'd8:    lg_r = ~(a_lg & b_lg);
      4'd9:    lg_r = ~(a_lg | b_lg);
      4'd10:   lg_r = ~(a_lg ^ b_lg);
      default: lg_r = 16'h0000;
    endcase
  end

  logic [15:0] sh_r;
  logic        sh_c;
  always_comb begin
    sh_r = 16'h0000;
    sh_c = 1'b0;
    case (s)
      4'd11:   begin sh_r = {a_sh[14:0], 1'b0};     sh_c = a_sh[15]; end
      4'd12:   begin sh_r = {1'b0, a_sh[15:1]};     sh_c = a_sh[0];  end
      4'd13:   begin sh_r = {a_sh[14:0], a_sh[15]}; sh_c = a_sh[15]; end
      4'd14:   begin sh_r = {a_sh[0], a_sh[15:1]};  sh_c = a_sh[0];  end
      default: begin sh_r = 16'h0000;              sh_c = 1'b0;     end
    endcase
  end

  logic [15:0] cmp_r;
  assign cmp_r = (a_cmp == b_cmp) ? 16'h0001 : 16'h0000;

  always_comb begin
    y_d = y_q;
    c_d = c_q;
    if (sel_ar) begin
      y_d = ar_r[15:0];
      c_d = ar_r[16];
    end else if (sel_lg) begin
      y_d = lg_r;
      c_d = 1'b0;
    end else if (sel_sh) begin
      y_d = sh_r;
      c_d = sh_c;
    end else if (sel_cmp) begin
      y_d = cmp_r;
      c_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 16'h0000;
      c_q <= 1'b0;
    end else begin
      y_q <= y_d;
      c_q <= c_d;
    end
  end

  assign yout  = y_q;
  assign carry = c_q;

endmodule

// File: tb/tb_alu16_lp.sv
// Randomised self-checking bench for alu16_lp against an arithmetic reference model.
module tb_alu16_lp;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic [15:0] yout;
  logic        carry;

  int passed = 0;
  int total  = 0;
  bit mon_on = 1'b0;

  logic [15:0] exp_y;
  logic        exp_c;

  alu16_lp dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .s(s),
    .yout(yout), .carry(carry)
  );

  always #5 clk = ~clk;

  // Reference: result/carry from the opcode table using plain integer math.
  function automatic logic [16:0] ref_f(input logic [3:0] op,
                                        input logic [15:0] av,
                                        input logic [15:0] bv);
    int unsigned ua, ub, r;
    logic c;
    ua = av; ub = bv; r = 0; c = 1'b0;
    case (op)
      4'd0:  begin r = ua + ub; c = (r > 32'hFFFF); end
      4'd1:  begin r = ua - ub; c = (ua < ub); end
      4'd2:  begin r = ua + 1;  c = (ua == 32'hFFFF); end
      4'd3:  begin r = ua - 1;  c = (ua == 0); end
      4'd4:  r = ua & ub;
      4'd5:  r = ua | ub;
      4'd6:  r = ua ^ ub;
      4'd7:  r = ~ua;
      4'd8:  r = ~(ua & ub);
      4'd9:  r = ~(ua | ub);
      4'd10: r = ~(ua ^ ub);
      4'd11: begin r = ua * 2;  c = (ua >= 32'h8000); end
      4'd12: begin r = ua / 2;  c = (ua % 2 == 1); end
      4'd13: begin r = ua * 2 + ua / 32'h8000; c = (ua >= 32'h8000); end
      4'd14: begin r = ua / 2 + (ua % 2) * 32'h8000; c = (ua % 2 == 1); end
      default: r = (ua == ub) ? 1 : 0;
    endcase
    return {c, r[15:0]};
  endfunction

  always @(posedge clk) begin
    logic [16:0] rv;
    rv = ref_f(s, a, b);
    if (rst) begin
      exp_y <= 16'h0000;
      exp_c <= 1'b0;
    end else if (en) begin
      exp_y <= rv[15:0];
      exp_c <= rv[16];
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (yout === exp_y && carry === exp_c) passed++;
      else $display("FAIL cycle_cmp: got %h/%b expected %h/%b", yout, carry, exp_y, exp_c);
    end
  end

  task automatic drive(input logic r, input logic e, input logic [3:0] op,
                       input logic [15:0] av, input logic [15:0] bv);
    rst = r; en = e; s = op; a = av; b = bv;
    @(posedge clk);
    #1;
  endtask

  // Literal check: pins both the DUT and the reference model.
  task automatic chk(input string nm, input logic [15:0] y, input logic c);
    total++;
    if (yout === y && carry === c && exp_y === y && exp_c === c) passed++;
    else $display("FAIL %s: dut %h/%b model %h/%b expected %h/%b",
                  nm, yout, carry, exp_y, exp_c, y, c);
  endtask

  initial begin
    drive(1'b1, 1'b1, 4'd0, 16'hFFFF, 16'hFFFF);
    mon_on = 1'b1;
    chk("reset", 16'h0000, 1'b0);

    drive(1'b0, 1'b1, 4'd0, 16'hFFFF, 16'h0001); chk("add_wrap", 16'h0000, 1'b1);
    drive(1'b0, 1'b1, 4'd1, 16'h0003, 16'h0005); chk("sub_borrow", 16'hFFFE, 1'b1);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h1234, 16'h1111);
      chk("hold", 16'hFFFE, 1'b1);
    end
    drive(1'b0, 1'b1, 4'd0, 16'h1234, 16'h1111); chk("add_after_hold", 16'h2345, 1'b0);

    drive(1'b0, 1'b1, 4'd11, 16'h8001, 16'h0000); chk("shl", 16'h0002, 1'b1);
    drive(1'b0, 1'b1, 4'd12, 16'h8001, 16'h0000); chk("shr", 16'h4000, 1'b1);
    drive(1'b0, 1'b1, 4'd13, 16'h8001, 16'h0000); chk("rol", 16'h0003, 1'b1);
    drive(1'b0, 1'b1, 4'd14, 16'h8001, 16'h0000); chk("ror", 16'hC000, 1'b1);

    drive(1'b0, 1'b1, 4'd4,  16'hF0F0, 16'hFF00); chk("and",  16'hF000, 1'b0);
    drive(1'b0, 1'b1, 4'd5,  16'hF0F0, 16'hFF00); chk("or",   16'hFFF0, 1'b0);
    drive(1'b0, 1'b1, 4'd6,  16'hF0F0, 16'hFF00); chk("xor",  16'h0FF0, 1'b0);
    drive(1'b0, 1'b1, 4'd8,  16'hF0F0, 16'hFF00); chk("nand", 16'h0FFF, 1'b0);
    drive(1'b0, 1'b1, 4'd10, 16'hF0F0, 16'hFF00); chk("xnor", 16'hF00F, 1'b0);
    drive(1'b0, 1'b1, 4'd15, 16'hABCD, 16'hABCD); chk("eq_true",  16'h0001, 1'b0);
    drive(1'b0, 1'b1, 4'd15, 16'hABCD, 16'hABCC); chk("eq_false", 16'h0000, 1'b0);
    drive(1'b0, 1'b1, 4'd3,  16'h0000, 16'h1234); chk("dec_zero", 16'hFFFF, 1'b1);
    drive(1'b0, 1'b1, 4'd7,  16'h00FF, 16'h1234); chk("not", 16'hFF00, 1'b0);

    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    drive(1'b1, 1'b1, 4'd0, 16'hFFFF, 16'h0001); chk("mid_reset", 16'h0000, 1'b0);
    drive(1'b0, 1'b1, 4'd2, 16'hFFFF, 16'h0000); chk("inc_wrap", 16'h0000, 1'b1);

    for (int i = 0; i < 10000; i++)
      drive(($urandom_range(0, 299) == 0), (i % 4 != 3),
            4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
